mul_seq_hs: RTL

- Parametrised sequential N-bit multiplier. Successor of the combinational 8-bit array multiplier unit.
- Takes two operands from two independent producers over rfd/dav_ handshakes.
- Computes the product with an N-iteration shift-and-add datapath. No combinational N×N array.
- Delivers the 2N-bit result to a consumer over a dav_/rfd handshake, replacing the old one-cycle ok pulse.

---
 rtl/mul_seq_hs.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mul_seq_hs.sv
// mul_seq_hs -- sequential N-bit x N-bit shift-and-add multiplier with
// rfd/dav_ handshakes on both operand producers and on the result consumer.
//
// Ports:
//   clock            system clock, all state on rising edge
//   reset            synchronous, active-high
//   rfd1, rfd2       ready-for-data to producers 1/2 (same register)
//   dav1_, dav2_     data-available from producers, active low
//   x, y             N-bit operands, captured only when both dav_ are low
//   sgn              (MUL_SEQ_SIGNED_EN only) treat x/y as two's complement
//   m                2N-bit product, stable while dav_out_ is low
//   dav_out_         result-available to consumer, active low
//   rfd_in           consumer ready-for-data, active high
//   busy             high while iterating
//
// Optional feature macro: MUL_SEQ_SIGNED_EN (adds the sgn input; magnitudes
// are multiplied and the product negated when the operand signs differ).
module mul_seq_hs #(
   parameter int N = 8
) (
   input  logic           clock,
   input  logic           reset,
   output logic           rfd1,
   input  logic           dav1_,
   input  logic [N-1:0]   x,
   output logic           rfd2,
   input  logic           dav2_,
   input  logic [N-1:0]   y,
`ifdef MUL_SEQ_SIGNED_EN
   input  logic           sgn,
`endif
   output logic [2*N-1:0] m,
   output logic           dav_out_,
   input  logic           rfd_in,
   output logic           busy
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_IN      = 3'd0,
      S_CALC    = 3'd1,
      S_IN_END  = 3'd2,
      S_OUT     = 3'd3,
      S_OUT_END = 3'd4
   } state_t;

   state_t         star;
   logic           rfd;
   logic [N-1:0]   x_r;
   logic [N-1:0]   acc;
   logic [N-1:0]   y_r;
   logic [CW-1:0]  count;
   logic           neg;

   logic [N:0]     sum;
   logic [N-1:0]   x_mag;
   logic [N-1:0]   y_mag;
   logic           neg_in;
   logic [2*N-1:0] prod;
   logic [2*N-1:0] prod_fix;

   // Both producers see the same ready flag.
   assign rfd1 = rfd;
   assign rfd2 = rfd;

   // Upper half plus X when the multiplier LSB is set; carry kept in bit N.
   always_comb begin
      sum = {1'b0, acc};
      if (y_r[0])
         sum = {1'b0, acc} + {1'b0, x_r};
   end

   // Operand conditioning on the capture edge. In signed mode the magnitude
   // of -2^(N-1) is 2^(N-1), which still fits the N-bit unsigned datapath.
   always_comb begin
      x_mag  = x;
      y_mag  = y;
      neg_in = 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
      if (sgn) begin
         if (x[N-1]) x_mag = ~x + 1'b1;
         if (y[N-1]) y_mag = ~y + 1'b1;
         neg_in = x[N-1] ^ y[N-1];
      end
`endif
   end

   assign prod = {acc, y_r};

   always_comb begin
      prod_fix = prod;
      if (neg)
         prod_fix = ~prod + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         star     <= S_IN;
         rfd      <= 1'b1;
         dav_out_ <= 1'b1;
         busy     <= 1'b0;
         m        <= '0;
         x_r      <= '0;
         acc      <= '0;
         y_r      <= '0;
         count    <= '0;
         neg      <= 1'b0;
      end else begin
         case (star)
            S_IN: begin
               // Capture only when both producers present data together.
               if (!dav1_ && !dav2_) begin
                  x_r   <= x_mag;
                  y_r   <= y_mag;
                  neg   <= neg_in;
                  acc   <= '0;
                  count <= CW'(N);
                  rfd   <= 1'b0;
                  busy  <= 1'b1;
                  star  <= S_CALC;
               end
            end
            S_CALC: begin
               // Shift {carry, sum, Y} right by one: carry lands in bit 2N-1,
               // sum LSB moves into the top of Y.
               acc   <= sum[N:1];
               y_r   <= {sum[0], y_r[N-1:1]};
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  busy <= 1'b0;
                  star <= S_IN_END;
               end
            end
            S_IN_END: begin
               if (dav1_ && dav2_) begin
                  m        <= prod_fix;
                  dav_out_ <= 1'b0;
                  star     <= S_OUT;
               end
            end
            S_OUT: begin
               if (!rfd_in) begin
                  dav_out_ <= 1'b1;
                  star     <= S_OUT_END;
               end
            end
            S_OUT_END: begin
               if (rfd_in) begin
                  rfd  <= 1'b1;
                  star <= S_IN;
               end
            end
            default: begin
               // Recover from an illegal encoding to the idle state.
               rfd      <= 1'b1;
               dav_out_ <= 1'b1;
               busy     <= 1'b0;
               star     <= S_IN;
            end
         endcase
      end
   end

endmodule
